// File: rtl/motion_bbox_pkg.sv
// Shared types and width helpers for the motion_bbox block.
package motion_bbox_pkg;

  typedef enum logic {
    SEEK_SOF,
    IN_FRAME
  } state_e;

  // Coordinate width for a dimension of n positions (at least 1 bit).
  function automatic int unsigned coord_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width needed to count every pixel of a w x h frame, including zero.
  function automatic int unsigned count_w(input int unsigned w, input int unsigned h);
    return $clog2(w * h + 1);
  endfunction

endpackage

// File: rtl/motion_bbox_if.sv
// Delta-pixel input stream plus per-frame result record port.
// MOTION_BBOX_CENTROID_EN adds the coordinate-sum fields.
interface motion_bbox_if #(
  parameter int unsigned XW = 10,
  parameter int unsigned YW = 9,
  parameter int unsigned CW = 19
);
  logic [7:0]    AXIS_In_tData;
  logic          AXIS_In_tValid;
  logic          AXIS_In_tReady;
  logic          AXIS_In_tUser;
  logic          AXIS_In_tLast;
  logic          Res_Valid;
  logic          Res_Ready;
  logic          Res_Found;
  logic [XW-1:0] Res_XMin;
  logic [XW-1:0] Res_XMax;
  logic [YW-1:0] Res_YMin;
  logic [YW-1:0] Res_YMax;
  logic [CW-1:0] Res_Count;
`ifdef MOTION_BBOX_CENTROID_EN
  logic [XW+CW-1:0] Res_SumX;
  logic [YW+CW-1:0] Res_SumY;
`endif

  modport slave (
    input  AXIS_In_tData, AXIS_In_tValid, AXIS_In_tUser, AXIS_In_tLast, Res_Ready,
    output AXIS_In_tReady, Res_Valid, Res_Found, Res_XMin, Res_XMax,
           Res_YMin, Res_YMax, Res_Count
`ifdef MOTION_BBOX_CENTROID_EN
    , output Res_SumX, Res_SumY
`endif
  );

  modport master (
    output AXIS_In_tData, AXIS_In_tValid, AXIS_In_tUser, AXIS_In_tLast, Res_Ready,
    input  AXIS_In_tReady, Res_Valid, Res_Found, Res_XMin, Res_XMax,
           Res_YMin, Res_YMax, Res_Count
`ifdef MOTION_BBOX_CENTROID_EN
    , input Res_SumX, Res_SumY
`endif
  );
endinterface

// File: rtl/motion_bbox_coord.sv
// Raster x/y counter driven by accepted beats, restarted by tUser.
// x/y present the coordinate of the beat currently on the bus.
module motion_bbox_coord #(
  parameter int unsigned WIDTH  = 640,
  parameter int unsigned HEIGHT = 480,
  parameter int unsigned XW     = 10,
  parameter int unsigned YW     = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          beat,
  input  logic          sof,
  input  logic          last,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          eol,
  output logic          eof,
  output logic          line_err
);
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic          at_end;

  // A tUser beat is pixel (0,0) regardless of the running count.
  assign x        = sof ? '0 : x_q;
  assign y        = sof ? '0 : y_q;
  assign at_end   = (x == XW'(WIDTH - 1));
  assign eol      = beat && last && at_end;
  assign eof      = eol && (y == YW'(HEIGHT - 1));
  assign line_err = beat && (last != at_end);

  // Advance the raster position on each accepted beat; errors rewind to origin.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q <= '0;
      y_q <= '0;
    end else if (beat) begin
      if (eol) begin
        x_q <= '0;
        y_q <= eof ? '0 : y + YW'(1);
      end else if (line_err) begin
        x_q <= '0;
        y_q <= '0;
      end else begin
        x_q <= x + XW'(1);
        y_q <= y;
      end
    end
  end
endmodule

// File: rtl/motion_bbox.sv
// Per-frame motion bounding box and pixel count from a delta-pixel stream.
// Optional feature macro: MOTION_BBOX_CENTROID_EN (adds Res_SumX/Res_SumY).
module motion_bbox
  import motion_bbox_pkg::*;
#(
  parameter int unsigned WIDTH  = 640,
  parameter int unsigned HEIGHT = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] Thresh,
  output logic       Sync_Err,
  output logic       Overrun,
  motion_bbox_if.slave bus
);
  localparam int unsigned XW = coord_w(WIDTH);
  localparam int unsigned YW = coord_w(HEIGHT);
  localparam int unsigned CW = count_w(WIDTH, HEIGHT);

  typedef struct packed {
    logic          found;
    logic [XW-1:0] xmin;
    logic [XW-1:0] xmax;
    logic [YW-1:0] ymin;
    logic [YW-1:0] ymax;
    logic [CW-1:0] count;
`ifdef MOTION_BBOX_CENTROID_EN
    logic [XW+CW-1:0] sumx;
    logic [YW+CW-1:0] sumy;
`endif
  } res_t;

  state_e        state;
  logic [7:0]    thr_q;
  logic          sof, take, motion, commit, tready_q, res_valid;
  logic [XW-1:0] cx, acc_xmin, acc_xmax, nxt_xmin, nxt_xmax;
  logic [YW-1:0] cy, acc_ymin, acc_ymax, nxt_ymin, nxt_ymax;
  logic [CW-1:0] acc_count, nxt_count;
  logic          eol, eof, line_err;
  res_t          res_q, res_d;
`ifdef MOTION_BBOX_CENTROID_EN
  logic [XW+CW-1:0] acc_sumx, nxt_sumx;
  logic [YW+CW-1:0] acc_sumy, nxt_sumy;
`endif

  assign sof    = bus.AXIS_In_tValid && bus.AXIS_In_tUser;
  // Outside a frame only a tUser beat is consumed.
  assign take   = bus.AXIS_In_tValid && ((state == IN_FRAME) || bus.AXIS_In_tUser);
  assign commit = take && eof;

  motion_bbox_coord #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .XW(XW), .YW(YW)) u_coord (
    .clk      (clk),
    .reset    (reset),
    .beat     (take),
    .sof      (sof),
    .last     (bus.AXIS_In_tLast),
    .x        (cx),
    .y        (cy),
    .eol      (eol),
    .eof      (eof),
    .line_err (line_err)
  );

  // Next accumulator values: a tUser beat starts from cleared state, and its
  // threshold is the live input since thr_q only captures it on this edge.
  always_comb begin
    motion    = bus.AXIS_In_tData > (sof ? Thresh : thr_q);
    nxt_xmin  = sof ? '1 : acc_xmin;
    nxt_xmax  = sof ? '0 : acc_xmax;
    nxt_ymin  = sof ? '1 : acc_ymin;
    nxt_ymax  = sof ? '0 : acc_ymax;
    nxt_count = sof ? '0 : acc_count;
`ifdef MOTION_BBOX_CENTROID_EN
    nxt_sumx  = sof ? '0 : acc_sumx;
    nxt_sumy  = sof ? '0 : acc_sumy;
`endif
    if (motion) begin
      if (cx < nxt_xmin) nxt_xmin = cx;
      if (cx > nxt_xmax) nxt_xmax = cx;
      if (cy < nxt_ymin) nxt_ymin = cy;
      if (cy > nxt_ymax) nxt_ymax = cy;
      nxt_count = nxt_count + CW'(1);
`ifdef MOTION_BBOX_CENTROID_EN
      nxt_sumx  = nxt_sumx + (XW+CW)'(cx);
      nxt_sumy  = nxt_sumy + (YW+CW)'(cy);
`endif
    end
    res_d       = '0;
    res_d.found = (nxt_count != '0);
    res_d.count = nxt_count;
    if (res_d.found) begin
      res_d.xmin = nxt_xmin;
      res_d.xmax = nxt_xmax;
      res_d.ymin = nxt_ymin;
      res_d.ymax = nxt_ymax;
`ifdef MOTION_BBOX_CENTROID_EN
      res_d.sumx = nxt_sumx;
      res_d.sumy = nxt_sumy;
`endif
    end
  end

  // Frame FSM, accumulators, sticky flags and result handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SEEK_SOF;
      thr_q     <= '0;
      acc_xmin  <= '1;
      acc_xmax  <= '0;
      acc_ymin  <= '1;
      acc_ymax  <= '0;
      acc_count <= '0;
`ifdef MOTION_BBOX_CENTROID_EN
      acc_sumx  <= '0;
      acc_sumy  <= '0;
`endif
      Sync_Err  <= 1'b0;
      Overrun   <= 1'b0;
      res_q     <= '0;
      res_valid <= 1'b0;
      tready_q  <= 1'b0;
    end else begin
      tready_q <= 1'b1;
      if (take) begin
        acc_xmin  <= nxt_xmin;
        acc_xmax  <= nxt_xmax;
        acc_ymin  <= nxt_ymin;
        acc_ymax  <= nxt_ymax;
        acc_count <= nxt_count;
`ifdef MOTION_BBOX_CENTROID_EN
        acc_sumx  <= nxt_sumx;
        acc_sumy  <= nxt_sumy;
`endif
        if (sof) thr_q <= Thresh;
        if ((sof && state == IN_FRAME) || line_err) Sync_Err <= 1'b1;
        state <= (line_err || eof) ? SEEK_SOF : IN_FRAME;
      end
      if (commit) begin
        res_q     <= res_d;
        res_valid <= 1'b1;
        if (res_valid && !bus.Res_Ready) Overrun <= 1'b1;
      end else if (res_valid && bus.Res_Ready) begin
        res_valid <= 1'b0;
      end
    end
  end

  assign bus.AXIS_In_tReady = tready_q;
  assign bus.Res_Valid      = res_valid;
  assign bus.Res_Found      = res_q.found;
  assign bus.Res_XMin       = res_q.xmin;
  assign bus.Res_XMax       = res_q.xmax;
  assign bus.Res_YMin       = res_q.ymin;
  assign bus.Res_YMax       = res_q.ymax;
  assign bus.Res_Count      = res_q.count;
`ifdef MOTION_BBOX_CENTROID_EN
  assign bus.Res_SumX       = res_q.sumx;
  assign bus.Res_SumY       = res_q.sumy;
`endif
endmodule

// File: tb/tb_motion_bbox.sv
// Directed bench for motion_bbox on an 8x4 raster with threshold 16.
module tb_motion_bbox;
  localparam int W = 8;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] Thresh = 8'd16;
  logic       Sync_Err;
  logic       Overrun;

  motion_bbox_if #(.XW(3), .YW(2), .CW(6)) bus ();

  motion_bbox #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk      (clk),
    .reset    (reset),
    .Thresh   (Thresh),
    .Sync_Err (Sync_Err),
    .Overrun  (Overrun),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         pa;
    logic [7:0] va;
    int         pb;
    logic [7:0] vb;
    int         found;
    int         xmin, xmax, ymin, ymax, count;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic beat(input logic [7:0] d, input logic u, input logic l);
    bus.AXIS_In_tData  = d;
    bus.AXIS_In_tUser  = u;
    bus.AXIS_In_tLast  = l;
    bus.AXIS_In_tValid = 1'b1;
    @(posedge clk); #1;
    bus.AXIS_In_tValid = 1'b0;
    bus.AXIS_In_tUser  = 1'b0;
    bus.AXIS_In_tLast  = 1'b0;
  endtask

  // Full frame, zero except two pixels (raster index y*W+x). Thresh is 16 on
  // the tUser beat and 255 afterwards, so only the sampled value may apply.
  task automatic send_frame(input int pa, input logic [7:0] va, input int pb, input logic [7:0] vb);
    for (int i = 0; i < W * H; i++) begin
      logic [7:0] d;
      d = (i == pa) ? va : ((i == pb) ? vb : 8'd0);
      if (i == 0) Thresh = 8'd16;
      beat(d, i == 0, (i % W) == W - 1);
      if (i == 0) Thresh = 8'hFF;
    end
  endtask

  task automatic check_res(input string tag, input int found, input int xmin, input int xmax,
                           input int ymin, input int ymax, input int count);
    chk({tag, ".valid"}, bus.Res_Valid, 1);
    chk({tag, ".found"}, bus.Res_Found, found);
    chk({tag, ".xmin"},  bus.Res_XMin,  xmin);
    chk({tag, ".xmax"},  bus.Res_XMax,  xmax);
    chk({tag, ".ymin"},  bus.Res_YMin,  ymin);
    chk({tag, ".ymax"},  bus.Res_YMax,  ymax);
    chk({tag, ".count"}, bus.Res_Count, count);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".tready"}, bus.AXIS_In_tReady, 0);
    chk({tag, ".valid"},  bus.Res_Valid, 0);
    chk({tag, ".found"},  bus.Res_Found, 0);
    chk({tag, ".xmin"},   bus.Res_XMin, 0);
    chk({tag, ".xmax"},   bus.Res_XMax, 0);
    chk({tag, ".ymin"},   bus.Res_YMin, 0);
    chk({tag, ".ymax"},   bus.Res_YMax, 0);
    chk({tag, ".count"},  bus.Res_Count, 0);
    chk({tag, ".sync"},   Sync_Err, 0);
    chk({tag, ".ovr"},    Overrun, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    //           pa  va      pb  vb      fnd xmn xmx ymn ymx cnt
    vecs[0] = '{10, 8'd20,  29, 8'd20,  1,  2,  5,  1,  3,  2};
    vecs[1] = '{-1, 8'd0,   -1, 8'd0,   0,  0,  0,  0,  0,  0};
    vecs[2] = '{19, 8'd16,  6,  8'd17,  1,  6,  6,  0,  0,  1};
    vecs[3] = '{0,  8'd255, 31, 8'd1,   1,  0,  0,  0,  0,  1};
    vecs[4] = '{31, 8'd200, 7,  8'd17,  1,  7,  7,  0,  3,  2};

    bus.AXIS_In_tData  = '0;
    bus.AXIS_In_tValid = 1'b0;
    bus.AXIS_In_tUser  = 1'b0;
    bus.AXIS_In_tLast  = 1'b0;
    bus.Res_Ready      = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b1;
    @(posedge clk); #1;
    chk("post_reset.tready", bus.AXIS_In_tReady, 1);
    chk("post_reset.valid", bus.Res_Valid, 0);

    for (int v = 0; v < 5; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      send_frame(vecs[v].pa, vecs[v].va, vecs[v].pb, vecs[v].vb);
      check_res(tag, vecs[v].found, vecs[v].xmin, vecs[v].xmax,
                vecs[v].ymin, vecs[v].ymax, vecs[v].count);
      @(posedge clk); #1;
      chk({tag, ".pulse_end"}, bus.Res_Valid, 0);
    end
    chk("vecs.sync", Sync_Err, 0);
    chk("vecs.ovr", Overrun, 0);

    // Short line: tLast at x=3 on row 1 aborts the frame.
    Thresh = 8'd16;
    for (int x = 0; x < W; x++) beat((x == 1) ? 8'd99 : 8'd0, x == 0, x == W - 1);
    chk("short.sync_before", Sync_Err, 0);
    for (int x = 0; x < 4; x++) beat(8'd0, 1'b0, x == 3);
    chk("short.sync", Sync_Err, 1);
    chk("short.valid", bus.Res_Valid, 0);
    for (int k = 0; k < 3; k++) beat(8'd200, 1'b0, k == 1);
    chk("short.junk_valid", bus.Res_Valid, 0);
    send_frame(10, 8'd20, 29, 8'd20);
    check_res("after_short", 1, 2, 5, 1, 3, 2);
    chk("after_short.sync_sticky", Sync_Err, 1);
    @(posedge clk); #1;

    // Two frames back to back with the consumer stalled.
    bus.Res_Ready = 1'b0;
    send_frame(10, 8'd20, 29, 8'd20);
    check_res("ovr_f1", 1, 2, 5, 1, 3, 2);
    chk("ovr_f1.ovr", Overrun, 0);
    send_frame(19, 8'd16, 6, 8'd17);
    check_res("ovr_f2", 1, 6, 6, 0, 0, 1);
    chk("ovr_f2.ovr", Overrun, 1);
    @(posedge clk); #1;
    chk("ovr_hold.valid", bus.Res_Valid, 1);
    bus.Res_Ready = 1'b1;
    @(posedge clk); #1;
    chk("ovr_accept.valid", bus.Res_Valid, 0);

    // Reset in the middle of a frame that already holds motion pixels.
    Thresh = 8'd16;
    for (int i = 0; i < 11; i++)
      beat((i == 1 || i == 10) ? 8'd200 : 8'd0, i == 0, (i % W) == W - 1);
    reset = 1'b0;
    #2;
    check_all_zero("midreset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    send_frame(10, 8'd20, 29, 8'd20);
    check_res("after_reset", 1, 2, 5, 1, 3, 2);
    chk("after_reset.sync", Sync_Err, 0);
    chk("after_reset.ovr", Overrun, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
